// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared constants and types for the two-requester RAM
//                arbiter: RAM geometry, requester ids, command and read-tag
//                records.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int ADDR_W  = 8;   // 256-word RAM
  localparam int DATA_W  = 16;  // RAM word width
  localparam int RAM_LAT = 1;   // registered address -> valid douta

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Travels alongside an outstanding read so the returning word can be
  // steered to the requester that issued it.
  typedef struct packed {
    logic     valid;
    port_id_e owner;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin pick. With both ports
//                eligible the port that did not win last time is chosen.
//  Ports       : elig[1:0]  eligibility, bit0 = A, bit1 = B
//                last_gnt   port that received the most recent grant
//                gnt[1:0]   one-hot winner (all zero when nobody eligible)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import ram_pkg::*;
(
  input  logic [1:0] elig,
  input  port_id_e   last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == PORT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb2
//  Description : Round-robin arbiter/sequencer placing one command per cycle
//                from requester A or B onto a single-port RAM, and returning
//                read data to the issuing requester with a valid pulse.
//  Ports       : clk, reset                 clock, sync active-high reset
//                a_req/a_we/a_addr/a_wdata  requester A command
//                a_gnt                      A command accepted (1 cycle)
//                a_rvalid/a_rdata           A read return
//                b_*                        same for requester B
//                ram_we/ram_addr/ram_din    registered RAM command
//                ram_dout                   RAM read data
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arb2
  import ram_pkg::*;
#(
  // Widths must agree with ram_pkg, whose command record is used internally.
  parameter int ADDR_W  = ram_pkg::ADDR_W,
  parameter int DATA_W  = ram_pkg::DATA_W,
  parameter int RAM_LAT = ram_pkg::RAM_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  port_id_e   last_gnt;
  logic [1:0] elig;
  logic [1:0] win;
  cmd_t       win_cmd;
  rd_tag_t    tag_in;
  rd_tag_t    tag_out;
  rd_tag_t    tag_sr [RAM_LAT];

  // A port whose grant pulse is still visible is held off for that cycle,
  // so a requester has a full cycle to drop or change its request.
  assign elig = {b_req & ~b_gnt, a_req & ~a_gnt};

  rr_arb2 u_rr_arb2 (
    .elig     (elig),
    .last_gnt (last_gnt),
    .gnt      (win)
  );

  // Inputs of the losing/idle port never reach the RAM command.
  always_comb begin
    win_cmd = '0;
    if (win[1]) begin
      win_cmd = '{we: b_we, addr: b_addr, wdata: b_wdata};
    end else if (win[0]) begin
      win_cmd = '{we: a_we, addr: a_addr, wdata: a_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      last_gnt <= PORT_B;
    end else begin
      a_gnt <= win[0];
      b_gnt <= win[1];
      if (|win) begin
        ram_we   <= win_cmd.we;
        ram_addr <= win_cmd.addr;
        ram_din  <= win_cmd.wdata;
        last_gnt <= win[1] ? PORT_B : PORT_A;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

  // The command registered last cycle is on the RAM port now; a read there
  // starts a tag that emerges from the shift register in step with douta.
  assign tag_in = '{valid: (a_gnt | b_gnt) & ~ram_we,
                    owner: b_gnt ? PORT_B : PORT_A};

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_sr[0] <= '0;
    end else begin
      tag_sr[0] <= tag_in;
    end
  end

  for (genvar i = 1; i < RAM_LAT; i++) begin : g_tag_stage
    always_ff @(posedge clk) begin
      if (reset) begin
        tag_sr[i] <= '0;
      end else begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign tag_out = tag_sr[RAM_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag_out.valid & (tag_out.owner == PORT_A);
      b_rvalid <= tag_out.valid & (tag_out.owner == PORT_B);
      if (tag_out.valid && tag_out.owner == PORT_A) a_rdata <= ram_dout;
      if (tag_out.valid && tag_out.owner == PORT_B) b_rdata <= ram_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arb2
//  Description : Self-checking bench for ram_arb2 with a behavioural
//                256x16 read-first RAM attached to the RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arb2;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout = 16'h0000;
  logic [15:0] mem [256];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ram_arb2 dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Read-first single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        rst;
    logic        ar, aw; logic [7:0] aa; logic [15:0] ad;
    logic        br, bw; logic [7:0] ba; logic [15:0] bd;
    logic        eag, ebg, ewe; logic [7:0] eaddr; logic [15:0] edin;
    logic        earv; logic [15:0] eard;
    logic        ebrv; logic [15:0] ebrd;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 16'h0000;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_we"},   {31'd0, ram_we},   32'd0);
    chk({tag, "_ram_addr"}, {24'd0, ram_addr}, 32'd0);
    chk({tag, "_ram_din"},  {16'd0, ram_din},  32'd0);
    chk({tag, "_gnts"},     {30'd0, a_gnt, b_gnt}, 32'd0);
    chk({tag, "_rvalids"},  {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk({tag, "_rdata"},    {a_rdata, b_rdata}, 32'd0);
  endtask

  initial begin
    int a_pulses;
    int b_pulses;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;
    mem[8'h20] = 16'hAAAA;
    mem[8'h30] = 16'hBBBB;

    //            rst   ar    aw    aa     ad         br    bw    ba     bd         eag   ebg   ewe   eaddr  edin       earv  eard       ebrv  ebrd
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h55, 16'hDEAD, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h02, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h02, 16'h0000, 1'b0, 16'h1111, 1'b1, 16'h2222};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h02, 16'h0000, 1'b0, 16'h1111, 1'b0, 16'h2222};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'hFF, 16'h1234, 1'b0, 1'b1, 1'b1, 8'hFF, 16'h1234, 1'b0, 16'h1111, 1'b0, 16'h2222};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'h77, 16'h9999, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h1234, 1'b0, 16'h1111, 1'b0, 16'h2222};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1111, 1'b0, 16'h2222};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1111, 1'b0, 16'h2222};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h2222};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h2222};

    // Reset held three cycles, then ten idle cycles.
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_outputs("rst_hold");
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ram_we", {31'd0, ram_we}, 32'd0);
    end

    // Directed vector table: write/read A, reset, simultaneous reads, RAW.
    for (int i = 0; i < 19; i++) begin
      reset   = tbl[i].rst;
      a_req   = tbl[i].ar; a_we = tbl[i].aw; a_addr = tbl[i].aa; a_wdata = tbl[i].ad;
      b_req   = tbl[i].br; b_we = tbl[i].bw; b_addr = tbl[i].ba; b_wdata = tbl[i].bd;
      tick();
      chk($sformatf("v%0d_a_gnt", i),    {31'd0, a_gnt},    {31'd0, tbl[i].eag});
      chk($sformatf("v%0d_b_gnt", i),    {31'd0, b_gnt},    {31'd0, tbl[i].ebg});
      chk($sformatf("v%0d_ram_we", i),   {31'd0, ram_we},   {31'd0, tbl[i].ewe});
      chk($sformatf("v%0d_ram_addr", i), {24'd0, ram_addr}, {24'd0, tbl[i].eaddr});
      chk($sformatf("v%0d_ram_din", i),  {16'd0, ram_din},  {16'd0, tbl[i].edin});
      chk($sformatf("v%0d_a_rvalid", i), {31'd0, a_rvalid}, {31'd0, tbl[i].earv});
      chk($sformatf("v%0d_a_rdata", i),  {16'd0, a_rdata},  {16'd0, tbl[i].eard});
      chk($sformatf("v%0d_b_rvalid", i), {31'd0, b_rvalid}, {31'd0, tbl[i].ebrv});
      chk($sformatf("v%0d_b_rdata", i),  {16'd0, b_rdata},  {16'd0, tbl[i].ebrd});
    end
    reset = 1'b0;
    idle_inputs();

    // Saturation: both requesters read continuously for 20 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_req = 1'b1; a_addr = 8'h20;
    b_req = 1'b1; b_addr = 8'h30;
    a_pulses = 0;
    b_pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k <= 20) begin
        chk($sformatf("sat%0d_a_gnt", k), {31'd0, a_gnt}, {31'd0, 1'(k % 2)});
        chk($sformatf("sat%0d_b_gnt", k), {31'd0, b_gnt}, {31'd0, 1'((k + 1) % 2)});
        chk($sformatf("sat%0d_ram_addr", k), {24'd0, ram_addr},
            (k % 2 == 1) ? 32'h20 : 32'h30);
      end
      if (k == 20) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      if (a_rvalid && b_rvalid) chk("sat_both_rvalid", 32'd1, 32'd0);
      if (a_rvalid) begin
        a_pulses++;
        chk("sat_a_rdata", {16'd0, a_rdata}, 32'hAAAA);
      end
      if (b_rvalid) begin
        b_pulses++;
        chk("sat_b_rdata", {16'd0, b_rdata}, 32'hBBBB);
      end
    end
    chk("sat_a_pulses", a_pulses, 32'd10);
    chk("sat_b_pulses", b_pulses, 32'd10);
    idle_inputs();

    // Reset lands while an A read is in flight.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_req = 1'b1; a_addr = 8'h01;
    tick();
    chk("mid_a_gnt", {31'd0, a_gnt}, 32'd1);
    a_req = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_outputs("mid_rst");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
